lanczos_coe_arbiter: RTL and testbench
======================================

// Module: lanczos_coe_arbiter
// PURPOSE
//  Shares one lanczos_table coefficient ROM between two scaler requesters:
//  0 = horizontal pass, 1 = vertical pass. Round-robin arbitration with a
//  valid/ready handshake. Drives the ROM address and tags each lookup
//  through the ROM latency. Returns the six coefficients to the requester
//  that issued the lookup. Sits between the scaler2 filter cores and the
//  single table instance.
// PARAMETERS
//  STEP       4096  phase resolution; ROM address width DXW = $clog2(STEP/4)
//  COE_WIDTH  10    width of one coefficient
//  TBL_LAT    1     ROM read latency in clk cycles (>=1)
// PORTS
//  clk        in   1             clock
//  rst        in   1             async reset, active-high
//  req0_valid in   1             requester 0 lookup request
//  req0_dx    in   DXW           requester 0 phase
//  req0_ready out  1             requester 0 request accepted this cycle
//  req1_valid in   1             requester 1 lookup request
//  req1_dx    in   DXW           requester 1 phase
//  req1_ready out  1             requester 1 request accepted this cycle
//  tbl_dx     out  DXW           ROM address (registered)
//  tbl_coe    in   6*COE_WIDTH   ROM data {coe5,...,coe0}, coe0 in LSBs
//  rsp0_valid out  1             coefficients for requester 0 valid
//  rsp1_valid out  1             coefficients for requester 1 valid
//  rsp_coe    out  6*COE_WIDTH   coefficient bus shared by both responses
//  gnt_cnt0   out  32            requester 0 grant count (macro only)
//  gnt_cnt1   out  32            requester 1 grant count (macro only)
// BEHAVIOUR
//  - Reset: req*_ready=0, tbl_dx=0, rsp*_valid=0, rsp_coe=0.
//    Tag pipe cleared. RR pointer last=1, so requester 0 wins first.
//  - req*_ready is combinational from req*_valid and the RR pointer.
//    At most one ready is high per cycle. ready is high only when the
//    matching valid is high.
//  - Acceptance: a request is accepted when valid & ready in cycle N.
//    Only requester i valid -> grant i. Both valid -> grant the one
//    that is not `last`. Neither valid -> no grant, pointer holds.
//    On a grant, last <= granted index.
//  - Requesters hold valid and dx stable until ready. Dropping valid
//    before ready is allowed and withdraws the request.
//  - Pipeline: at N+1, tbl_dx = granted dx. ROM data is valid at
//    N+1+TBL_LAT. rsp_coe and rsp<i>_valid are registered at
//    N+2+TBL_LAT. Total latency is TBL_LAT+2 (3 at the default).
//  - Tag pipe: {valid, sel}, depth TBL_LAT+1. One lookup per cycle
//    sustained, so throughput is 1 per cycle.
//  - Responses: no backpressure; consumers must accept rsp every cycle.
//    rsp*_valid is a 1-cycle pulse per accepted request.
//    rsp0_valid and rsp1_valid are never high together.
//    rsp_coe holds its last value when no response is valid.
//  - Ordering: responses appear in grant order, with no reordering or drops.
//  - tbl_dx holds its last value in idle cycles (no spurious toggling).
//  - Reset mid-operation: in-flight lookups are discarded and no rsp is
//    emitted after rst deasserts. The first grant after reset goes to 0.
//  - Bit widths: dx is passed through unmodified. No arithmetic on
//    coefficients.
// CONFIGURATION
//  LANCZOS_ARB_STAT_EN defined:
//    gnt_cnt0/gnt_cnt1 increment by 1 per grant to the requester.
//    They wrap from 2^32-1 to 0 and reset to 0.
//  Undefined:
//    the counters are not built and gnt_cnt0/gnt_cnt1 are tied to 0.
//  Arbitration and latency are identical in both builds.
// TESTING
//  1. Only req0 valid, dx=0x155 -> req0_ready the same cycle; tbl_dx=0x155
//     at +1; rsp0_valid pulse at +3 with rsp_coe = ROM[0x155].
//  2. Both valid continuously from reset -> grants 0,1,0,1...
//     Responses alternate rsp0/rsp1 every cycle, 1 result per cycle.
//  3. req1 alone for 3 cycles, then both valid -> the next grant goes to 0
//     (last=1).
//  4. rst pulsed 1 cycle after 2 back-to-back grants -> no rsp*_valid
//     after rst. Next lookup grants req0 with latency 3.
//  5. Idle gaps between requests -> tbl_dx holds its value; rsp_coe holds;
//     no valid pulses.
//  6. With LANCZOS_ARB_STAT_EN: 5 grants to req0, 3 to req1 ->
//     gnt_cnt0=5, gnt_cnt1=3. Without the macro: both read 0.

Source files
------------

// File: rtl/lanczos_coe_arbiter.sv
// Round-robin arbiter sharing one lanczos coefficient ROM between the horizontal (0)
// and vertical (1) scaler passes. Optional grant counters: LANCZOS_ARB_STAT_EN.
module lanczos_coe_arbiter #(
  parameter int STEP      = 4096,
  parameter int COE_WIDTH = 10,
  parameter int TBL_LAT   = 1,
  localparam int DXW      = $clog2(STEP / 4),
  localparam int CW       = 6 * COE_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [DXW-1:0] req0_dx,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [DXW-1:0] req1_dx,
  output logic           req1_ready,
  output logic [DXW-1:0] tbl_dx,
  input  logic [CW-1:0]  tbl_coe,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [CW-1:0]  rsp_coe,
  output logic [31:0]    gnt_cnt0,
  output logic [31:0]    gnt_cnt1
);

  // Handshake: a request transfers in any cycle where valid && ready; ready is
  // combinational, at most one is high, and requesters hold dx while waiting.
  logic           r_last;
  logic [DXW-1:0] r_tbl_dx;
  logic [TBL_LAT:0] r_tag_v;
  logic [TBL_LAT:0] r_tag_sel;
  logic           r_rsp0_valid;
  logic           r_rsp1_valid;
  logic [CW-1:0]  r_rsp_coe;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_gnt_any;

  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    if (!rst) begin
      w_gnt0 = req0_valid & (~req1_valid | r_last);
      w_gnt1 = req1_valid & (~req0_valid | ~r_last);
    end
    w_gnt_any = w_gnt0 | w_gnt1;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_tbl_dx <= '0;
    end else if (w_gnt_any) begin
      r_last   <= w_gnt1;
      r_tbl_dx <= w_gnt1 ? req1_dx : req0_dx;
    end
  end

  // Stage 0 lines up with tbl_dx; stage TBL_LAT lines up with valid ROM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_sel <= '0;
    end else begin
      r_tag_v   <= {r_tag_v[TBL_LAT-1:0], w_gnt_any};
      r_tag_sel <= {r_tag_sel[TBL_LAT-1:0], w_gnt1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_coe    <= '0;
    end else begin
      r_rsp0_valid <= r_tag_v[TBL_LAT] & ~r_tag_sel[TBL_LAT];
      r_rsp1_valid <= r_tag_v[TBL_LAT] & r_tag_sel[TBL_LAT];
      if (r_tag_v[TBL_LAT]) r_rsp_coe <= tbl_coe;
    end
  end

  assign tbl_dx     = r_tbl_dx;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_coe    = r_rsp_coe;

`ifdef LANCZOS_ARB_STAT_EN
  logic [31:0] r_gnt_cnt0;
  logic [31:0] r_gnt_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_gnt0) r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
      if (w_gnt1) r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`else
  assign gnt_cnt0 = 32'd0;
  assign gnt_cnt1 = 32'd0;
`endif

endmodule

// File: tb/tb_lanczos_coe_arbiter.sv
// Bench for lanczos_coe_arbiter: directed scenarios plus random request traffic
// checked against a grant-order response queue and a behavioural ROM.
module tb_lanczos_coe_arbiter;
  localparam int DXW = 10;
  localparam int CW  = 60;
  localparam int LAT = 1;
  localparam int W   = 1 + CW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0_valid = 1'b0;
  logic [DXW-1:0] req0_dx = '0;
  logic           req0_ready;
  logic           req1_valid = 1'b0;
  logic [DXW-1:0] req1_dx = '0;
  logic           req1_ready;
  logic [DXW-1:0] tbl_dx;
  logic [CW-1:0]  tbl_coe;
  logic           rsp0_valid;
  logic           rsp1_valid;
  logic [CW-1:0]  rsp_coe;
  logic [31:0]    gnt_cnt0;
  logic [31:0]    gnt_cnt1;

  lanczos_coe_arbiter #(.STEP(4096), .COE_WIDTH(10), .TBL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dx(req0_dx), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dx(req1_dx), .req1_ready(req1_ready),
    .tbl_dx(tbl_dx), .tbl_coe(tbl_coe),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_coe(rsp_coe),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ROM: arbitrary distinct content per address, LAT-cycle read
  function automatic logic [CW-1:0] rom_f(input logic [DXW-1:0] a);
    logic [9:0] c0, c1, c2, c3, c4, c5;
    c0 = a;
    c1 = a ^ 10'h0f0;
    c2 = 10'(a * 3);
    c3 = ~a;
    c4 = 10'(a + 1);
    c5 = a ^ 10'h2a5;
    return {c5, c4, c3, c2, c1, c0};
  endfunction

  logic [CW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_f(tbl_dx);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign tbl_coe = rom_pipe[LAT-1];

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic          m_last = 1'b1;
  logic [DXW-1:0] exp_tbl = '0;
  logic [CW-1:0]  exp_coe = '0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef LANCZOS_ARB_STAT_EN
    check_eq({tag, "_cnt0"}, 64'(gnt_cnt0), 64'(exp_cnt0));
    check_eq({tag, "_cnt1"}, 64'(gnt_cnt1), 64'(exp_cnt1));
`else
    check_eq({tag, "_cnt0"}, 64'(gnt_cnt0), 64'd0);
    check_eq({tag, "_cnt1"}, 64'(gnt_cnt1), 64'd0);
`endif
  endtask

  // one clock: check registered outputs, drive requests, check readies, update model
  task automatic step(input logic v0, input logic [DXW-1:0] d0,
                      input logic v1, input logic [DXW-1:0] d1,
                      output logic g0, output logic g1);
    logic e0, e1;
    logic [W-1:0] ent;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      ent = exp_q.pop_front();
      void'(due_q.pop_front());
      e0 = ~ent[CW];
      e1 = ent[CW];
      exp_coe = ent[CW-1:0];
    end
    check_eq("rsp0_valid", 64'(rsp0_valid), 64'(e0));
    check_eq("rsp1_valid", 64'(rsp1_valid), 64'(e1));
    check_eq("rsp_coe", 64'(rsp_coe), 64'(exp_coe));
    check_eq("tbl_dx", 64'(tbl_dx), 64'(exp_tbl));
    req0_valid = v0; req0_dx = d0;
    req1_valid = v1; req1_dx = d1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (v0 && v1) begin
      if (m_last) g0 = 1'b1; else g1 = 1'b1;
    end else if (v0) g0 = 1'b1;
    else if (v1) g1 = 1'b1;
    check_eq("req0_ready", 64'(req0_ready), 64'(g0));
    check_eq("req1_ready", 64'(req1_ready), 64'(g1));
    if (g0 || g1) begin
      m_last  = g1;
      exp_tbl = g1 ? d1 : d0;
      exp_q.push_back({g1, rom_f(exp_tbl)});
      due_q.push_back(cyc + 3);
      if (g0) exp_cnt0++; else exp_cnt1++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    m_last = 1'b1;
    exp_tbl = '0;
    exp_coe = '0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    check_eq("rst_ready0", 64'(req0_ready), 64'd0);
    check_eq("rst_ready1", 64'(req1_ready), 64'd0);
    check_eq("rst_tbl_dx", 64'(tbl_dx), 64'd0);
    check_eq("rst_rsp0", 64'(rsp0_valid), 64'd0);
    check_eq("rst_rsp1", 64'(rsp1_valid), 64'd0);
    check_eq("rst_coe", 64'(rsp_coe), 64'd0);
    check_counters("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, g0, g1);
  endtask

  logic g0, g1;
  logic pend0, pend1;
  logic [DXW-1:0] dx0, dx1;

  initial begin
    do_reset();

    // single lookup from requester 0
    step(1'b1, 10'h155, 1'b0, '0, g0, g1);
    idle(5);

    // both valid continuously: alternate grants, one response per cycle
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 10'(i * 37), 1'b1, 10'(900 - i), g0, g1);
    idle(5);

    // requester 1 alone, then both: requester 0 wins next
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 10'(100 + i), g0, g1);
    step(1'b1, 10'h3ff, 1'b1, 10'h001, g0, g1);
    check_eq("t3_gnt_after_r1", 64'(req0_ready), 64'd1);
    idle(5);

    // reset with lookups in flight: nothing emitted afterwards
    step(1'b1, 10'h0aa, 1'b0, '0, g0, g1);
    step(1'b0, '0, 1'b1, 10'h0bb, g0, g1);
    do_reset();
    idle(4);
    step(1'b1, 10'h123, 1'b1, 10'h321, g0, g1);
    idle(5);

    // idle gaps between lookups: outputs hold
    step(1'b0, '0, 1'b1, 10'h2f0, g0, g1);
    idle(6);
    step(1'b1, 10'h011, 1'b0, '0, g0, g1);
    idle(6);

    // grant counters: 5 to requester 0, 3 to requester 1
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 10'(i), 1'b0, '0, g0, g1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 10'(i + 50), g0, g1);
    idle(4);
    check_counters("t6");

    // random traffic with holds and withdrawals
    pend0 = 1'b0; pend1 = 1'b0; dx0 = '0; dx1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend0 && $urandom_range(0, 99) < 55) begin
        pend0 = 1'b1; dx0 = 10'($urandom);
      end else if (pend0 && $urandom_range(0, 99) < 5) pend0 = 1'b0;
      if (!pend1 && $urandom_range(0, 99) < 55) begin
        pend1 = 1'b1; dx1 = 10'($urandom);
      end else if (pend1 && $urandom_range(0, 99) < 5) pend1 = 1'b0;
      step(pend0, dx0, pend1, dx1, g0, g1);
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
      if (i == 300) begin
        do_reset();
        pend0 = 1'b0; pend1 = 1'b0;
      end
    end
    idle(6);
    check_counters("final");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
